debounce_test_sequencer: RTL



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_test_sequencer_tick_window_counter.sv | 29 ++
 rtl/debounce_test_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce measurement sequencer.
// The state encoding is exported on o_state, so the values are fixed.
package debounce_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ARMED   = 3'd2,
    MEASURE = 3'd3,
    SETTLE  = 3'd4,
    DONE    = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_test_sequencer_tick_window_counter.sv
// Slow-tick counter with synchronous clear. o_reached flags the tick that
// brings the count to i_term, so the caller can act in that same cycle.
module tick_window_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_reached
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  // i_term is at least 1, so the subtraction cannot wrap.
  assign o_reached = i_en && (r_count == (i_term - W'(1)));

endmodule

// File: rtl/debounce_test_sequencer.sv
// Runs one bounce-measurement session: clear, arm on first raw edge,
// measure for a window of slow ticks, settle, then capture the counts.
module debounce_test_sequencer
  import debounce_pkg::*;
#(
  parameter int WINDOW_TICKS      = 50,
  parameter int ARM_TIMEOUT_TICKS = 200,
  parameter int CNT_W             = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_slow_tick,
  input  logic [CNT_W-1:0] i_lvl_count,
  input  logic [CNT_W-1:0] i_lvl_db_count,
  output logic             o_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_raw_edges,
  output logic [CNT_W-1:0] o_db_edges,
  output logic [CNT_W-1:0] o_bounce_extra,
  output logic [2:0]       o_state
);

  localparam int TICK_W = $clog2(max_int(WINDOW_TICKS, ARM_TIMEOUT_TICKS) + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state, w_state_next;
  logic             r_settle;
  logic             r_done, r_timeout, r_overflow;
  logic [CNT_W-1:0] r_raw, r_db, r_extra;

  logic              w_tick_clr, w_tick_en, w_reached;
  logic              w_capture, w_set_timeout, w_clear_flags, w_overflow_hit;
  logic [TICK_W-1:0] w_term;
  logic [CNT_W-1:0]  w_extra;

  // One counter serves both the arm timeout and the measurement window.
  assign w_term    = (r_state == ARMED) ? TICK_W'(ARM_TIMEOUT_TICKS) : TICK_W'(WINDOW_TICKS);
  assign w_tick_en = i_slow_tick && ((r_state == ARMED) || (r_state == MEASURE));

  tick_window_counter #(.W(TICK_W)) u_tick_counter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_tick_clr),
    .i_en      (w_tick_en),
    .i_term    (w_term),
    .o_reached (w_reached)
  );

  always_comb begin
    w_state_next  = r_state;
    w_tick_clr    = 1'b0;
    w_capture     = 1'b0;
    w_set_timeout = 1'b0;
    w_clear_flags = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_clr = 1'b1;
        if (i_start) begin
          w_state_next  = CLEAR;
          w_clear_flags = 1'b1;
        end
      end
      CLEAR: begin
        w_tick_clr   = 1'b1;
        w_state_next = ARMED;
      end
      ARMED: begin
        if (i_lvl_count != '0) begin
          w_state_next = MEASURE;
          w_tick_clr   = 1'b1;
        end else if (w_reached) begin
          w_state_next  = IDLE;
          w_set_timeout = 1'b1;
        end
      end
      MEASURE: begin
        if (w_reached) w_state_next = SETTLE;
      end
      SETTLE: begin
        if (r_settle) begin
          w_state_next = DONE;
          w_capture    = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_abort && (r_state != IDLE)) begin
      w_state_next  = IDLE;
      w_tick_clr    = 1'b1;
      w_capture     = 1'b0;
      w_set_timeout = 1'b0;
    end
  end

  assign w_overflow_hit = ((r_state == ARMED) || (r_state == MEASURE)) &&
                          ((i_lvl_count == CNT_MAX) || (i_lvl_db_count == CNT_MAX));
  assign w_extra = (i_lvl_count >= i_lvl_db_count) ? (i_lvl_count - i_lvl_db_count) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_settle   <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
      r_raw      <= '0;
      r_db       <= '0;
      r_extra    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_settle <= (r_state == SETTLE);
      r_done   <= w_capture;
      if (w_clear_flags)      r_timeout <= 1'b0;
      else if (w_set_timeout) r_timeout <= 1'b1;
      if (w_clear_flags)       r_overflow <= 1'b0;
      else if (w_overflow_hit) r_overflow <= 1'b1;
      if (w_capture) begin
        r_raw   <= i_lvl_count;
        r_db    <= i_lvl_db_count;
        r_extra <= w_extra;
      end
    end
  end

  assign o_clr          = (r_state == CLEAR);
  assign o_busy         = (r_state == CLEAR) || (r_state == ARMED) ||
                          (r_state == MEASURE) || (r_state == SETTLE);
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;
  assign o_overflow     = r_overflow;
  assign o_raw_edges    = r_raw;
  assign o_db_edges     = r_db;
  assign o_bounce_extra = r_extra;
  assign o_state        = r_state;

endmodule
